// File: rtl/lzc_normalizer.sv
// lzc_normalizer: multi-cycle 32-bit leading-zero normalizer.
// A single 16-bit leading-zero counter is shared between the upper and lower
// halves of the operand. The upper half is examined first. The lower half is
// examined only when the upper half is all zeros. The word is then shifted
// left so that bit 31 is set.

// lzc16: combinational 16-bit leading-zero counter, result 0..16.
module lzc16 (
  input  logic [15:0] value,
  output logic [4:0]  count
);

  // Scan from LSB to MSB so that the highest set bit determines the count.
  always_comb begin
    count = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (value[i]) begin
        count = 5'(15 - i);
      end
    end
  end

endmodule

module lzc_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_count,
  output logic        out_zero,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] operand;
  logic [5:0]  count;
  logic [15:0] lzc_in;
  logic [4:0]  lzc_res;

  // Select the operand half for the shared counter; the counter sees zero when idle.
  always_comb begin
    lzc_in = 16'h0000;
    case (state)
      HI:      lzc_in = operand[31:16];
      LO:      lzc_in = operand[15:0];
      default: lzc_in = 16'h0000;
    endcase
  end

  lzc16 u_lzc (
    .value (lzc_in),
    .count (lzc_res)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. HI falls through to LO only when the upper half is zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = HI;
      HI:      state_next = lzc_res[4] ? LO : SHIFT;
      LO:      state_next = SHIFT;
      SHIFT:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the operand, accumulate the count, and load the result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand   <= 32'h0;
      count     <= 6'd0;
      out_data  <= 32'h0;
      out_count <= 6'd0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand <= in_data;
          end
        end
        HI: begin
          if (!lzc_res[4]) begin
            count <= {1'b0, lzc_res};
          end
        end
        LO: begin
          count <= 6'd16 + {1'b0, lzc_res};
        end
        SHIFT: begin
          // The 6-bit shift amount lets a count of 32 clear the word.
          out_data  <= operand << count;
          out_count <= count;
          out_zero  <= (count == 6'd32);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lzc_normalizer.sv
// tb_lzc_normalizer: table-driven and scoreboard-checked bench for lzc_normalizer.
module tb_lzc_normalizer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;
  logic        out_zero;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  count;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    exp_t        e;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp;
  int   n_fail;

  lzc_normalizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference normalizer: a full 32-bit scan, independent of the split-half design.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   c;
    c = 32;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) c = 31 - i;
    end
    e.count = 6'(c);
    e.zero  = (c == 32);
    e.data  = (c == 32) ? 32'h0 : (w << c);
    return e;
  endfunction

  // Drive one word, push its expectation at the handshake edge, and measure latency.
  task automatic applyStimulus(input logic [31:0] word, input exp_t e, input int lat);
    int n;
    int guard;
    in_data  = word;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checkVal("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("latency", 32'(n), 32'(lat));
  endtask

  // Pop the oldest expectation and compare against the presented result.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkVal("out_valid", 32'(out_valid), 32'd1);
    checkVal("out_data", out_data, e.data);
    checkVal("out_count", 32'(out_count), 32'(e.count));
    checkVal("out_zero", 32'(out_zero), 32'(e.zero));
  endtask

  task automatic consumeResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("valid_drop", 32'(out_valid), 32'd0);
    checkVal("ready_rise", 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t        ea;
    exp_t        eb;
    logic [31:0] w;
    bit          seen;
    int          n;

    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    vecs[0] = '{32'h0001_2345, '{32'h91A2_8000, 6'd15, 1'b0}, 3};
    vecs[1] = '{32'h0000_0001, '{32'h8000_0000, 6'd31, 1'b0}, 4};
    vecs[2] = '{32'h8000_0000, '{32'h8000_0000, 6'd0,  1'b0}, 3};
    vecs[3] = '{32'h0000_0000, '{32'h0000_0000, 6'd32, 1'b1}, 4};
    vecs[4] = '{32'h0000_FFFF, '{32'hFFFF_0000, 6'd16, 1'b0}, 4};
    vecs[5] = '{32'h0001_0000, '{32'h8000_0000, 6'd15, 1'b0}, 3};
    vecs[6] = '{32'h0000_8000, '{32'h8000_0000, 6'd16, 1'b0}, 4};
    vecs[7] = '{32'h7FFF_FFFF, '{32'hFFFF_FFFE, 6'd1,  1'b0}, 3};

    // Reset asserted before the first clock edge: outputs must already be at reset values.
    #1;
    checkVal("rst_out_valid", 32'(out_valid), 32'd0);
    checkVal("rst_out_data", out_data, 32'h0);
    checkVal("rst_out_count", 32'(out_count), 32'd0);
    checkVal("rst_out_zero", 32'(out_zero), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_in_ready", 32'(in_ready), 32'd1);
    #10;
    reset = 1'b0;
    #1;
    checkVal("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].word, vecs[i].e, vecs[i].lat);
      checkOutput();
      consumeResult();
    end

    // Random words with varied leading-zero counts, checked against the model.
    for (int i = 0; i < 8; i++) begin
      w = $urandom >> $urandom_range(0, 31);
      applyStimulus(w, model(w), (w[31:16] != 16'h0) ? 3 : 4);
      checkOutput();
      consumeResult();
    end

    // Backpressure: the held result must stay stable and a pending word must wait.
    $display("[TB] backpressure sequence");
    ea = '{32'hF000_0000, 6'd8, 1'b0};
    eb = '{32'hC000_0000, 6'd30, 1'b0};
    applyStimulus(32'h00F0_0000, ea, 3);
    checkOutput();
    in_data  = 32'h0000_0003;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkVal("bp_valid", 32'(out_valid), 32'd1);
      checkVal("bp_in_ready", 32'(in_ready), 32'd0);
      checkVal("bp_data", out_data, 32'hF000_0000);
      checkVal("bp_count", 32'(out_count), 32'd8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("bp_consume_ready", 32'(in_ready), 32'd1);
    checkVal("bp_consume_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    sb.push_back(eb);
    #1;
    in_valid = 1'b0;
    checkVal("bp_captured", 32'(busy), 32'd1);
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("bp_latency", 32'(n), 32'd4);
    checkOutput();
    consumeResult();

    // Reset while the lower half is being counted: no result may appear.
    $display("[TB] reset mid-operation sequence");
    in_data  = 32'h0000_0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkVal("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("mid_rst_busy", 32'(busy), 32'd0);
    checkVal("mid_rst_valid", 32'(out_valid), 32'd0);
    checkVal("mid_rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkVal("mid_no_valid", 32'(seen), 32'd0);
    applyStimulus(32'h0000_0345, '{32'hD140_0000, 6'd22, 1'b0}, 4);
    checkOutput();
    consumeResult();

    // Asynchronous reset while a zero result is held in DONE.
    applyStimulus(32'h0000_0000, '{32'h0000_0000, 6'd32, 1'b1}, 4);
    checkOutput();
    #2;
    reset = 1'b1;
    #1;
    checkVal("done_rst_valid", 32'(out_valid), 32'd0);
    checkVal("done_rst_count", 32'(out_count), 32'd0);
    checkVal("done_rst_zero", 32'(out_zero), 32'd0);
    checkVal("done_rst_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
